// File: rtl/strobe_monitor.sv
// strobe_monitor: measures strobe pulse widths, counts pulses, flags width and idle violations
module strobe_monitor #(
    parameter int CNT_W     = 16,
    parameter int MIN_WIDTH = 1,
    parameter int MAX_WIDTH = 1000,
    parameter int TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] width_o,
    output logic             width_valid_o,
    output logic [CNT_W-1:0] pulse_cnt_o,
    output logic             busy_o,
    output logic             too_short_o,
    output logic             too_long_o,
    output logic             idle_timeout_o
);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] W_SAT  = '1;
    localparam logic [CNT_W-1:0] W_LONG = CNT_W'(MAX_WIDTH + 1);
    localparam logic [CNT_W-1:0] W_MIN  = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] T_OUT  = CNT_W'(TIMEOUT);
    typedef enum logic {IDLE, HIGH} state_t;
    state_t state;
    logic strobe_q, rise, short_c, long_c, idle_c;
    logic [CNT_W-1:0] wcnt, icnt, pc_c, icnt_c;
    // clear takes effect first; events in the same cycle build on these values
    always_comb begin
        rise    = strobe_i & ~strobe_q;
        pc_c    = clear_i ? '0 : pulse_cnt_o;
        icnt_c  = clear_i ? '0 : icnt;
        short_c = clear_i ? 1'b0 : too_short_o;
        long_c  = clear_i ? 1'b0 : too_long_o;
        idle_c  = clear_i ? 1'b0 : idle_timeout_o;
    end
    // pulse tracking FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            strobe_q       <= 1'b1;
            wcnt           <= '0;
            icnt           <= '0;
            width_o        <= '0;
            width_valid_o  <= 1'b0;
            pulse_cnt_o    <= '0;
            busy_o         <= 1'b0;
            too_short_o    <= 1'b0;
            too_long_o     <= 1'b0;
            idle_timeout_o <= 1'b0;
        end else begin
            strobe_q       <= strobe_i;
            width_valid_o  <= 1'b0;
            pulse_cnt_o    <= pc_c;
            icnt           <= icnt_c;
            too_short_o    <= short_c;
            too_long_o     <= long_c;
            idle_timeout_o <= idle_c;
            if (state == IDLE) begin
                if (rise) begin
                    state  <= HIGH;
                    busy_o <= 1'b1;
                    wcnt   <= ONE;
                    icnt   <= '0;
                end else if (!strobe_i && icnt_c != T_OUT) begin
                    icnt <= icnt_c + ONE;
                    if (icnt_c + ONE == T_OUT) idle_timeout_o <= 1'b1;
                end
            end else if (strobe_i) begin
                if (wcnt != W_SAT) wcnt <= wcnt + ONE;
                if (wcnt != W_SAT && wcnt + ONE == W_LONG) too_long_o <= 1'b1;
            end else begin
                state         <= IDLE;
                busy_o        <= 1'b0;
                width_o       <= wcnt;
                width_valid_o <= 1'b1;
                pulse_cnt_o   <= pc_c + ONE;
                icnt          <= ONE;
                if (wcnt < W_MIN) too_short_o <= 1'b1;
                if (ONE == T_OUT) idle_timeout_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_strobe_monitor.sv
// tb_strobe_monitor: directed checks of strobe_monitor with default and small parameter sets
module tb_strobe_monitor;
    logic clk = 0, rst = 1, strobe = 1, clear = 0;
    logic [15:0] width_a, pc_a;
    logic wv_a, busy_a, short_a, long_a, idle_a;
    logic [3:0] width_b, pc_b;
    logic wv_b, busy_b, short_b, long_b, idle_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    strobe_monitor dut_a (
        .clk(clk), .rst(rst), .strobe_i(strobe), .clear_i(clear),
        .width_o(width_a), .width_valid_o(wv_a), .pulse_cnt_o(pc_a), .busy_o(busy_a),
        .too_short_o(short_a), .too_long_o(long_a), .idle_timeout_o(idle_a)
    );

    strobe_monitor #(.CNT_W(4), .MIN_WIDTH(3), .MAX_WIDTH(8), .TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .strobe_i(strobe), .clear_i(clear),
        .width_o(width_b), .width_valid_o(wv_b), .pulse_cnt_o(pc_b), .busy_o(busy_b),
        .too_short_o(short_b), .too_long_o(long_b), .idle_timeout_o(idle_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with strobe held high through release
        tick();
        tick();
        chk("rst_width", 32'(width_a), 0);
        chk("rst_pc", 32'(pc_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_flags", {short_a, long_a, idle_a, wv_a}, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_busy", 32'(busy_a), 0);
            chk("held_wv", 32'(wv_a), 0);
        end
        strobe = 0;
        tick();
        chk("held_end_wv", 32'(wv_a), 0);
        chk("held_end_pc", 32'(pc_a), 0);
        chk("held_end_busy", 32'(busy_a), 0);
        // 5-high pulse, 20 low
        strobe = 1;
        tick();
        chk("p5_busy", 32'(busy_a), 1);
        for (int i = 0; i < 4; i++) tick();
        strobe = 0;
        tick();
        chk("p5_wv", 32'(wv_a), 1);
        chk("p5_width", 32'(width_a), 5);
        chk("p5_pc", 32'(pc_a), 1);
        chk("p5_busy_end", 32'(busy_a), 0);
        tick();
        chk("p5_wv_once", 32'(wv_a), 0);
        for (int i = 0; i < 18; i++) tick();
        chk("p5_flags", {short_a, long_a, idle_a}, 0);
        chk("p5_width_hold", 32'(width_a), 5);
        // small-parameter instance: idle timeout after reset
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 9; i++) tick();
        chk("to_9", 32'(idle_b), 0);
        tick();
        chk("to_10", 32'(idle_b), 1);
        clear = 1;
        tick();
        clear = 0;
        chk("to_clear", 32'(idle_b), 0);
        // too-short pulse followed by a 9-low gap
        strobe = 1;
        tick();
        tick();
        strobe = 0;
        tick();
        chk("short_width", 32'(width_b), 2);
        chk("short_flag", 32'(short_b), 1);
        chk("short_pc", 32'(pc_b), 1);
        chk("short_wv", 32'(wv_b), 1);
        for (int i = 0; i < 8; i++) tick();
        chk("gap9_idle", 32'(idle_b), 0);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_short", 32'(short_b), 0);
        chk("clr_pc", 32'(pc_b), 0);
        // too-long pulse of 12 cycles
        strobe = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("long_8", 32'(long_b), 0);
        tick();
        chk("long_9", 32'(long_b), 1);
        chk("long_9_busy", 32'(busy_b), 1);
        for (int i = 0; i < 3; i++) tick();
        strobe = 0;
        tick();
        chk("long_width", 32'(width_b), 12);
        chk("long_wv", 32'(wv_b), 1);
        chk("long_keep", 32'(long_b), 1);
        chk("long_pc", 32'(pc_b), 1);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_long", 32'(long_b), 0);
        chk("clr_pc2", 32'(pc_b), 0);
        // back-to-back 4-high / 1-low pulses
        for (int p = 0; p < 3; p++) begin
            strobe = 1;
            for (int i = 0; i < 4; i++) tick();
            strobe = 0;
            tick();
            chk("b2b_width", 32'(width_b), 4);
            chk("b2b_wv", 32'(wv_b), 1);
        end
        chk("b2b_pc", 32'(pc_b), 3);
        chk("b2b_flags", {short_b, long_b, idle_b}, 0);
        // 14 more pulses: 17 total wraps a 4-bit counter to 1
        for (int p = 0; p < 14; p++) begin
            strobe = 1;
            for (int i = 0; i < 4; i++) tick();
            strobe = 0;
            tick();
        end
        chk("wrap_pc", 32'(pc_b), 1);
        // clear coincident with a short pulse end
        strobe = 1;
        tick();
        tick();
        strobe = 0;
        clear = 1;
        tick();
        clear = 0;
        chk("clr_end_pc", 32'(pc_b), 1);
        chk("clr_end_short", 32'(short_b), 1);
        chk("clr_end_width", 32'(width_b), 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
